// File: rtl/tile_scheduler_pkg.sv
// Shared constants and FSM state type for the tile scheduler and the output coordinator.
package tile_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN
  } state_e;

  // MACs PE(0,0) completes per cycle; sets block injection spacing.
  localparam int unsigned MACS_PER_CYCLE = 4;
  localparam int unsigned MIN_N          = 3;

endpackage

// File: rtl/tile_scheduler_if.sv
// Control/status bundle between the tile scheduler and its controller/coordinator.
interface tile_scheduler_if #(
  parameter int N_BITS = 5
) ();

  logic              start;
  logic [N_BITS-1:0] mat_size;
  logic              stall;
  logic              last_pe_valid;
  logic              input_valid;
  logic [N_BITS-1:0] pos_row;
  logic [N_BITS-1:0] pos_col;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport slave (
    input  start, mat_size, stall, last_pe_valid,
    output input_valid, pos_row, pos_col, busy, done, cfg_err
  );

  modport master (
    output start, mat_size, stall, last_pe_valid,
    input  input_valid, pos_row, pos_col, busy, done, cfg_err
  );

endinterface

// File: rtl/tile_scheduler.sv
// Walks an NxN output in ROWSxCOLS blocks, spacing one injection pulse per block,
// then waits for every block to retire at the last PE before signalling done.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int MAX_N  = 16,
  parameter int N_BITS = $clog2(MAX_N + 1),
  parameter int T_BITS = $clog2(((MAX_N + ROWS - 1) / ROWS) * ((MAX_N + COLS - 1) / COLS) + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  tile_scheduler_if.slave  bus
);

  localparam int NW = N_BITS + 1;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] n_q, n_d;
  logic [N_BITS-1:0] c_q, c_d;
  logic [N_BITS-1:0] gap_q, gap_d;
  logic [T_BITS-1:0] tiles_q, tiles_d;
  logic [T_BITS-1:0] issued_q, issued_d;
  logic [T_BITS-1:0] retired_q, retired_d;
  logic [N_BITS-1:0] nxt_row_q, nxt_row_d;
  logic [N_BITS-1:0] nxt_col_q, nxt_col_d;

  logic              iv_q, iv_d;
  logic [N_BITS-1:0] pos_row_q, pos_row_d;
  logic [N_BITS-1:0] pos_col_q, pos_col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic [NW-1:0]     n_ext;
  logic              legal;
  logic              accept;
  logic              issue;
  logic              retire;
  logic [NW-1:0]     tr, tc;
  logic [N_BITS-1:0] c_new;
  logic [T_BITS-1:0] tiles_new;

  logic [N_BITS-1:0] cur_n, cur_c, cur_row, cur_col;
  logic [T_BITS-1:0] cur_tiles, cur_issued;
  logic [NW-1:0]     col_sum;

  assign n_ext     = {1'b0, bus.mat_size};
  assign legal     = (n_ext >= NW'(MIN_N)) && (n_ext <= NW'(MAX_N));
  assign accept    = (state_q == S_IDLE) && bus.start && legal;
  assign retire    = (state_q != S_IDLE) && bus.last_pe_valid;
  assign tr        = (n_ext + NW'(ROWS - 1)) / NW'(ROWS);
  assign tc        = (n_ext + NW'(COLS - 1)) / NW'(COLS);
  assign c_new     = N_BITS'((n_ext + NW'(MACS_PER_CYCLE - 1)) / NW'(MACS_PER_CYCLE));
  assign tiles_new = T_BITS'(tr) * T_BITS'(tc);

  // The accepting edge already performs the first issue, so the issue path
  // works from freshly computed run parameters when leaving IDLE.
  always_comb begin
    if (accept) begin
      cur_n      = bus.mat_size;
      cur_c      = c_new;
      cur_tiles  = tiles_new;
      cur_issued = '0;
      cur_row    = '0;
      cur_col    = '0;
    end else begin
      cur_n      = n_q;
      cur_c      = c_q;
      cur_tiles  = tiles_q;
      cur_issued = issued_q;
      cur_row    = nxt_row_q;
      cur_col    = nxt_col_q;
    end
  end

  assign issue   = !bus.stall && (accept || (state_q == S_ISSUE));
  assign col_sum = {1'b0, cur_col} + NW'(COLS);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    c_d       = c_q;
    gap_d     = gap_q;
    tiles_d   = tiles_q;
    issued_d  = issued_q;
    retired_d = retired_q + T_BITS'(retire);
    nxt_row_d = nxt_row_q;
    nxt_col_d = nxt_col_q;
    iv_d      = 1'b0;
    pos_row_d = pos_row_q;
    pos_col_d = pos_col_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (legal) begin
            n_d       = bus.mat_size;
            c_d       = c_new;
            tiles_d   = tiles_new;
            issued_d  = '0;
            retired_d = '0;
            nxt_row_d = '0;
            nxt_col_d = '0;
            gap_d     = '0;
            busy_d    = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (!bus.stall) begin
          gap_d = gap_q - N_BITS'(1);
          if (gap_q <= N_BITS'(1)) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (retired_d == tiles_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (issue) begin
      iv_d      = 1'b1;
      pos_row_d = cur_row;
      pos_col_d = cur_col;
      issued_d  = cur_issued + T_BITS'(1);
      if (issued_d == cur_tiles) begin
        state_d = S_DRAIN;
      end else begin
        if (col_sum >= {1'b0, cur_n}) begin
          nxt_col_d = '0;
          nxt_row_d = cur_row + N_BITS'(ROWS);
        end else begin
          nxt_col_d = N_BITS'(col_sum);
          nxt_row_d = cur_row;
        end
        if (cur_c == N_BITS'(1)) begin
          state_d = S_ISSUE;
        end else begin
          gap_d   = cur_c - N_BITS'(1);
          state_d = S_GAP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      c_q       <= '0;
      gap_q     <= '0;
      tiles_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      nxt_row_q <= '0;
      nxt_col_q <= '0;
      iv_q      <= 1'b0;
      pos_row_q <= '0;
      pos_col_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      c_q       <= c_d;
      gap_q     <= gap_d;
      tiles_q   <= tiles_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      nxt_row_q <= nxt_row_d;
      nxt_col_q <= nxt_col_d;
      iv_q      <= iv_d;
      pos_row_q <= pos_row_d;
      pos_col_q <= pos_col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.input_valid = iv_q;
  assign bus.pos_row     = pos_row_q;
  assign bus.pos_col     = pos_col_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule
